uart_rx_core: RTL

- 8N1 UART receiver for the user project area. Samples the serial input pad (mprj_io[5]) with 16x oversampling.
- Validates the start and stop bits, then buffers received bytes in a small FIFO.
- Presents bytes to firmware-facing logic through a valid/ready pop interface.
- It is the receiving end of the serial stream that the testbench UART model drives (tx_start/tx_data/tx_busy).

---
 rtl/uart_rx_core.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling, majority-voted bits and a small receive FIFO.
// A byte becomes visible one clock after its stop-bit mid-sample; the pop is valid/ready and a full FIFO drops bytes.
module uart_rx_core #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  input  logic                        rx_en,
  input  logic [DIV_W-1:0]            clk_div,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        frame_err,
  output logic                        overrun,
  input  logic                        err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, hist_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       samp_q, samp_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             s7_q, s7_d, s8_q, s8_d;
  logic             busy_q;
  logic             frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             fall, tick, maj, push, ferr_set, pop, full, do_push, ovr_set;

  assign fall = hist_q & ~sync2_q;
  assign tick = (state_q != S_IDLE) && (div_q == clk_div);
  // Samples 7 and 8 are held; sample 9 is the live synced value.
  assign maj  = (s7_q & s8_q) | (s7_q & sync2_q) | (s8_q & sync2_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q + DIV_ONE;
    samp_d   = samp_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    s7_d     = s7_q;
    s8_d     = s8_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    if (tick) begin
      div_d  = '0;
      samp_d = samp_q + 4'd1;
      if (samp_q == 4'd7) s7_d = sync2_q;
      if (samp_q == 4'd8) s8_d = sync2_q;
    end
    unique case (state_q)
      S_IDLE: begin
        div_d  = '0;
        samp_d = '0;
        if (fall && rx_en) state_d = S_START;
      end
      S_START: if (tick) begin
        if (samp_q == 4'd9 && maj) begin
          state_d = S_IDLE;
        end else if (samp_q == 4'd15) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: if (tick) begin
        if (samp_q == 4'd9) shift_d = {maj, shift_q[7:1]};
        if (samp_q == 4'd15) begin
          if (bit_q == 3'd7) state_d = S_STOP;
          bit_d = bit_q + 3'd1;
        end
      end
      S_STOP: if (tick && samp_q == 4'd9) begin
        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
        if (maj) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          ferr_set = 1'b1;
          state_d  = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: if (sync2_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!rx_en) begin
      state_d  = S_IDLE;
      push     = 1'b0;
      ferr_set = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      s7_q    <= 1'b0;
      s8_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign rx_valid = (cnt_q != '0);
  assign full     = (cnt_q == DEPTH_C);
  assign pop      = rx_valid && rx_ready;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push  = push && (!full || pop);
  assign ovr_set  = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= shift_q;
        wr_q        <= wr_q + PTR_ONE;
      end
      if (pop) rd_q <= rd_q + PTR_ONE;
      if (do_push && !pop)      cnt_q <= cnt_q + CNT_ONE;
      else if (!do_push && pop) cnt_q <= cnt_q - CNT_ONE;
    end
  end

  assign frame_err_d = ferr_set | (frame_err_q & ~err_clr);
  assign overrun_d   = ovr_set | (overrun_q & ~err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data    = mem_q[rd_q];
  assign fifo_level = cnt_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
endmodule
